flag_cond_unit: RTL and testbench

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

---
 rtl/flag_cond_pkg.sv | 38 +++
 rtl/flag_cond_unit_cond_eval.sv | 40 ++++
 rtl/flag_cond_unit.sv | 98 +++++++++
 tb/tb_flag_cond_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/flag_cond_pkg.sv
// Shared constants for the flag/condition unit: flag bit positions,
// condition codes, ALU operation classes and the default stack depth.
package flag_cond_pkg;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned STK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_LOGIC  = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ADDSUB = 2'b10,
    OP_MUL    = 2'b11
  } op_class_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_code_e;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational decode of a condition code against a ZNCV flag vector.
module cond_eval
  import flag_cond_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_code,
  output logic       result
);

  logic z, n, c, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    result = 1'b0;
    case (cond_code_e'(cond_code))
      COND_EQ: result = z;
      COND_NE: result = !z;
      COND_CS: result = c;
      COND_CC: result = !c;
      COND_MI: result = n;
      COND_PL: result = !n;
      COND_VS: result = v;
      COND_VC: result = !v;
      COND_HI: result = c & !z;
      COND_LS: result = !c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = !z & (n == v);
      COND_LE: result = z | (n != v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// ZNCV flag register with a LIFO save stack, sticky stack error and a
// registered condition evaluator.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int unsigned STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sta_in,
  input  logic [1:0] op_en,
  input  logic       sta_we,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  input  logic       cond_req,
  input  logic [3:0] cond_code,
  output logic [3:0] flags,
  output logic       cond_valid,
  output logic       cond_true,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  localparam int unsigned CNT_W = $clog2(STK_DEPTH + 1);
  localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [CNT_W-1:0] count;
  logic [3:0]       stk_mem [STK_DEPTH];
  logic [3:0]       flags_next;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic             do_push, do_pop, err_set, eval_result;

  assign stk_full  = (count == CNT_W'(STK_DEPTH));
  assign stk_empty = (count == '0);

  // Simultaneous push and pop cancel out entirely, including error detection.
  assign do_push = push & ~pop & ~stk_full;
  assign do_pop  = pop & ~push & ~stk_empty;
  assign err_set = (push & ~pop & stk_full) | (pop & ~push & stk_empty);

  assign push_idx = IDX_W'(count);
  assign pop_idx  = IDX_W'(count - 1'b1);

  always_comb begin
    flags_next = flags;
    if (do_pop) begin
      flags_next = stk_mem[pop_idx];
    end else if (sta_we) begin
      case (op_class_e'(op_en))
        OP_ADDSUB, OP_MUL: flags_next = sta_in;
        default: begin
          flags_next[FLAG_Z] = sta_in[FLAG_Z];
          flags_next[FLAG_N] = sta_in[FLAG_N];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= '0;
      count      <= '0;
      stk_err    <= 1'b0;
      cond_valid <= 1'b0;
      cond_true  <= 1'b0;
    end else begin
      flags      <= flags_next;
      cond_valid <= cond_req;
      cond_true  <= cond_req & eval_result;
      if (do_push) begin
        count <= count + 1'b1;
      end else if (do_pop) begin
        count <= count - 1'b1;
      end
      if (err_set) begin
        stk_err <= 1'b1;
      end else if (err_clr) begin
        stk_err <= 1'b0;
      end
    end
  end

  // Entry storage is left unreset; entries above the count are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stk_mem[push_idx] <= flags;
    end
  end

  cond_eval u_cond_eval (
    .flags     (flags),
    .cond_code (cond_code),
    .result    (eval_result)
  );

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_flag_cond_unit;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sta_in;
  logic [1:0] op_en;
  logic       sta_we, push, pop, err_clr, cond_req;
  logic [3:0] cond_code;
  logic [3:0] flags;
  logic       cond_valid, cond_true, stk_full, stk_empty, stk_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err, m_cv, m_ct;

  flag_cond_unit #(.STK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sta_in     (sta_in),
    .op_en      (op_en),
    .sta_we     (sta_we),
    .push       (push),
    .pop        (pop),
    .err_clr    (err_clr),
    .cond_req   (cond_req),
    .cond_code  (cond_code),
    .flags      (flags),
    .cond_valid (cond_valid),
    .cond_true  (cond_true),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input int code);
    bit z = f[3], n = f[2], c = f[1], v = f[0];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'(m_flags));
    check({tag, ".cv"},    32'(cond_valid), 32'(m_cv));
    check({tag, ".ct"},    32'(cond_true), 32'(m_ct));
    check({tag, ".full"},  32'(stk_full), 32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stk_empty), 32'(m_stack.size() == 0));
    check({tag, ".err"},   32'(stk_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
    m_cv  = 1'b0;
    m_ct  = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare every output.
  task automatic step(input string tag, input logic [3:0] s_in, input logic [1:0] op,
                      input logic we, input logic pu, input logic po, input logic ec,
                      input logic cr, input logic [3:0] cc);
    int sz;
    sta_in = s_in; op_en = op; sta_we = we; push = pu; pop = po;
    err_clr = ec; cond_req = cr; cond_code = cc;
    @(posedge clk);
    #1;
    sz   = m_stack.size();
    m_cv = cr;
    m_ct = cr && ref_cond(m_flags, int'(cc));
    if ((pu && !po && sz == DEPTH) || (po && !pu && sz == 0)) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    if (pu && !po && sz < DEPTH) m_stack.push_back(m_flags);
    if (po && !pu && sz > 0) m_flags = m_stack.pop_back();
    else if (we) m_flags = op[1] ? s_in : {s_in[3:2], m_flags[1:0]};
    sta_we = 0; push = 0; pop = 0; err_clr = 0; cond_req = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 4'h0, 2'b00, 0, 0, 0, 0, 0, 4'h0);
  endtask

  // Reset asserted and released between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst");
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; sta_in = '0; op_en = '0; sta_we = 0; push = 0; pop = 0;
    err_clr = 0; cond_req = 0; cond_code = '0;
    model_reset();
    #2;
    check_all("rst0");
    #10;
    rst_n = 1;

    // Full update then logic-class partial update.
    step("ld_add", 4'b0111, 2'b10, 1, 0, 0, 0, 0, 4'h0);
    check("ld_add_val", 32'(flags), 32'b0111);
    step("ld_log", 4'b1000, 2'b00, 1, 0, 0, 0, 0, 4'h0);
    check("ld_log_val", 32'(flags), 32'b1011);

    // HI / LS with C=1, Z=0.
    step("ld_c", 4'b0010, 2'b11, 1, 0, 0, 0, 0, 4'h0);
    step("hi", 4'h0, 2'b00, 0, 0, 0, 0, 1, 4'd8);
    check("hi_v", 32'({cond_valid, cond_true}), 32'b11);
    step("ls", 4'h0, 2'b00, 0, 0, 0, 0, 1, 4'd9);
    check("ls_v", 32'({cond_valid, cond_true}), 32'b10);
    idle("post_cond");
    check("cv_idle", 32'({cond_valid, cond_true}), 32'b00);

    // Overflow: five pushes into a four-entry stack.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      step("ovf_push", 4'(i), 2'b10, 1, 1, 0, 0, 0, 4'h0);
      if (i == 3) check("full_at4", 32'({stk_full, stk_err}), 32'b10);
    end
    check("ovf_err", 32'({stk_full, stk_err}), 32'b11);
    step("ovf_clr", 4'h0, 2'b00, 0, 0, 0, 1, 0, 4'h0);
    check("err_clr", 32'(stk_err), 32'b0);
    step("pp_noop", 4'h0, 2'b00, 0, 1, 1, 0, 0, 4'h0);
    check("pp_noop_err", 32'(stk_err), 32'b0);

    // Push/load/pop round trip, then underflow.
    pulse_reset();
    step("ld5", 4'b0101, 2'b10, 1, 0, 0, 0, 0, 4'h0);
    step("push5", 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'h0);
    step("ldC", 4'b1100, 2'b10, 1, 0, 0, 0, 0, 4'h0);
    step("pop5", 4'h0, 2'b00, 0, 0, 1, 0, 0, 4'h0);
    check("pop5_val", 32'({flags, stk_empty}), 32'b01011);
    step("udf", 4'h0, 2'b00, 0, 0, 1, 0, 0, 4'h0);
    check("udf_val", 32'({flags, stk_err}), 32'b01011);

    // Underflow colliding with err_clr: error wins.
    step("udf_clr", 4'h0, 2'b00, 0, 0, 1, 1, 0, 4'h0);
    check("err_wins", 32'(stk_err), 32'b1);

    // Pop beats sta_we.
    pulse_reset();
    step("ld1", 4'b0001, 2'b10, 1, 0, 0, 0, 0, 4'h0);
    step("push1", 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'h0);
    step("ld_x", 4'b0110, 2'b10, 1, 0, 0, 0, 0, 4'h0);
    step("pop_we", 4'b1110, 2'b10, 1, 0, 1, 0, 0, 4'h0);
    check("pop_we_val", 32'(flags), 32'b0001);

    // Push with sta_we saves the old flags.
    step("push_we", 4'b1001, 2'b10, 1, 1, 0, 0, 0, 4'h0);
    step("pop_old", 4'h0, 2'b00, 0, 0, 1, 0, 0, 4'h0);
    check("push_we_val", 32'(flags), 32'b0001);

    // Asynchronous reset with count=2, stk_err=1 and a pending evaluation.
    step("a_pop", 4'h0, 2'b00, 0, 0, 1, 0, 0, 4'h0);
    step("a_ld", 4'b1111, 2'b10, 1, 1, 0, 0, 0, 4'h0);
    step("a_push", 4'h0, 2'b00, 0, 1, 0, 0, 1, 4'd14);
    check("a_pre", 32'({stk_err, stk_empty, cond_valid}), 32'b101);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("arst");
    check("arst_val", 32'({flags, stk_empty, stk_full, stk_err, cond_valid, cond_true}), 32'b000010000);
    #1;
    rst_n = 1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step("rnd", 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom));
      if (i % 700 == 699) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
